uart_tx_serializer: RTL

//  UART transmit stage driven by the baud rate generator's tx tick.

---
 rtl/uart_tx_serializer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-buffered UART transmitter, frames sent LSB-first, one bit per tx_tick_i
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   tx_tick_i          one-cycle pulse per bit period
//   data_i, valid_i    byte to queue; accepted when valid_i & ready_o
//   ready_o            FIFO not full
//   stop2_i            two stop bits, latched when a frame is popped
//   parity_odd_i       parity sense, latched at pop (used only with UART_TX_PARITY_EN)
//   tx_o               registered serial line, idle high
//   busy_o             frame in progress
//   fifo_count_o       occupied FIFO entries
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        tx_tick_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        stop2_i,
  input  logic                        parity_odd_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DATA_W-1:0] shift, shift_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic tx_q, tx_n, stop2_q, stop2_n, stop_sec, stop_sec_n, push, pop;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
`else
  logic unused_parity;
  assign unused_parity = parity_odd_i;
`endif
  assign ready_o = count < (AW+1)'(FIFO_DEPTH);
  assign push = valid_i & ready_o;
  assign tx_o = tx_q;
  assign busy_o = state != IDLE;
  assign fifo_count_o = count;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      tx_q <= 1'b1;
      stop2_q <= 1'b0;
      stop_sec <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx_q <= tx_n;
      stop2_q <= stop2_n;
      stop_sec <= stop_sec_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end
  // Pops happen from IDLE or at the end of STOP; the pop block below loads the
  // next frame and overrides whatever the state branch chose.
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    tx_n = tx_q;
    stop2_n = stop2_q;
    stop_sec_n = stop_sec;
    pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n = par_q;
`endif
    if (tx_tick_i) begin
      case (state)
        IDLE: begin
          pop = count != '0;
          tx_n = 1'b1;
        end
        START: begin
          tx_n = shift[0];
          bit_cnt_n = '0;
          state_n = DATA;
        end
        DATA: begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_n = par_q;
            state_n = PARITY;
`else
            tx_n = 1'b1;
            state_n = STOP;
`endif
          end else begin
            shift_n = shift >> 1;
            tx_n = shift[1];
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_n = 1'b1;
          state_n = STOP;
        end
`endif
        STOP: begin
          if (stop2_q && !stop_sec) stop_sec_n = 1'b1;
          else begin
            pop = count != '0;
            tx_n = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (pop) begin
      shift_n = mem[rd_ptr];
      stop2_n = stop2_i;
      stop_sec_n = 1'b0;
      tx_n = 1'b0;
      state_n = START;
`ifdef UART_TX_PARITY_EN
      par_n = ^mem[rd_ptr] ^ parity_odd_i;
`endif
    end
  end
endmodule
